// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback receiver.
// Optional load-wait timeout is enabled with WB_LD_TIMEOUT_EN.
package wb_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [AW_DEF-1:0]   rd;
    logic                we;
    logic                is_ld;
    logic [XLEN_DEF-1:0] wbv;
  } wb_req_t;

endpackage

// File: rtl/wb_ld_timer.sv
// Load-wait counter; flags expiry on the wait cycle that brings the count to TIMEOUT.
// Only instantiated when WB_LD_TIMEOUT_EN is defined.
module wb_ld_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_writeback.sv
// Writeback receiver: one registered register-file write per accepted instruction.
// Define WB_LD_TIMEOUT_EN to abandon loads whose response never arrives.
module wb_writeback
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [AW-1:0]   ex_rd,
  input  logic            ex_we,
  input  logic            ex_is_ld,
  input  logic [XLEN-1:0] ex_wbv,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] wb_wbv,
  output logic            busy,
  output logic            err
);

  wb_state_t       state_q, state_d;
  logic [AW-1:0]   ld_rd_q, ld_rd_d;
  logic            ld_we_q, ld_we_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] wb_wbv_q, wb_wbv_d;
  logic            err_q, err_d;
  logic            accept_ld;
  logic            timeout_hit;

  assign accept_ld = (state_q == IDLE) && ex_valid && ex_is_ld;

`ifdef WB_LD_TIMEOUT_EN
  wb_ld_timer #(.TIMEOUT(TIMEOUT)) u_ld_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept_ld),
    .run_i     ((state_q == WAIT_LD) && !ld_valid),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    wb_wbv_d   = wb_wbv_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        // A response with no load outstanding is spurious, even alongside a load accept.
        if (ld_valid) err_d = 1'b1;
        if (ex_valid) begin
          if (ex_is_ld) begin
            ld_rd_d = ex_rd;
            ld_we_d = ex_we;
            state_d = WAIT_LD;
          end else if (ex_we && (ex_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ex_rd;
            wb_wbv_d   = ex_wbv;
          end
        end
      end
      WAIT_LD: begin
        if (ld_valid) begin
          state_d = IDLE;
          if (ld_we_q && (ld_rd_q != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_rd_q;
            wb_wbv_d   = ld_data;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      wb_wbv_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      wb_wbv_q   <= wb_wbv_d;
      err_q      <= err_d;
    end
  end

  assign ex_ready = (state_q == IDLE);
  assign busy     = (state_q == WAIT_LD);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign wb_wbv   = wb_wbv_q;
  assign err      = err_q;

endmodule

// File: tb/tb_wb_writeback.sv
// Directed self-checking bench for wb_writeback; timeout steps follow WB_LD_TIMEOUT_EN.
module tb_wb_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd = '0;
  logic        ex_we = 1'b0;
  logic        ex_is_ld = 1'b0;
  logic [31:0] ex_wbv = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] wb_wbv;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  wb_writeback #(.XLEN(32), .AW(5), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_rd    (ex_rd),
    .ex_we    (ex_we),
    .ex_is_ld (ex_is_ld),
    .ex_wbv   (ex_wbv),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .wb_wbv   (wb_wbv),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic we,
                          input logic is_ld, input logic [31:0] wbv);
    ex_valid = v;
    ex_rd    = rd;
    ex_we    = we;
    ex_is_ld = is_ld;
    ex_wbv   = wbv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wbv", wb_wbv, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(ex_ready), 32'd1);
    rst = 1'b0;
    step();

    // Single ALU write, pulse lasts one cycle, data holds afterwards
    drive_ex(1'b1, 5'd3, 1'b1, 1'b0, 32'hDEADBEEF);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    check("alu_we", 32'(rf_we), 32'd1);
    check("alu_waddr", 32'(rf_waddr), 32'd3);
    check("alu_wbv", wb_wbv, 32'hDEADBEEF);
    step();
    check("alu_we_pulse", 32'(rf_we), 32'd0);
    check("alu_wbv_hold", wb_wbv, 32'hDEADBEEF);
    check("alu_waddr_hold", 32'(rf_waddr), 32'd3);

    // Back-to-back ALU results
    drive_ex(1'b1, 5'd1, 1'b1, 1'b0, 32'h11);
    check("b2b_ready0", 32'(ex_ready), 32'd1);
    step();
    check("b2b_we0", 32'(rf_we), 32'd1);
    check("b2b_waddr0", 32'(rf_waddr), 32'd1);
    check("b2b_wbv0", wb_wbv, 32'h11);
    check("b2b_ready1", 32'(ex_ready), 32'd1);
    drive_ex(1'b1, 5'd2, 1'b1, 1'b0, 32'h22);
    step();
    check("b2b_we1", 32'(rf_we), 32'd1);
    check("b2b_waddr1", 32'(rf_waddr), 32'd2);
    check("b2b_wbv1", wb_wbv, 32'h22);
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    check("b2b_we_end", 32'(rf_we), 32'd0);

    // Load to rd=5, response after four wait cycles, ALU op held meanwhile
    drive_ex(1'b1, 5'd5, 1'b1, 1'b1, 32'h12345678);
    step();
    drive_ex(1'b1, 5'd7, 1'b1, 1'b0, 32'h77);
    for (int i = 0; i < 4; i++) begin
      check("ld_busy", 32'(busy), 32'd1);
      check("ld_ready", 32'(ex_ready), 32'd0);
      check("ld_no_we", 32'(rf_we), 32'd0);
      if (i == 3) begin
        ld_valid = 1'b1;
        ld_data  = 32'hCAFE0001;
      end
      step();
    end
    ld_valid = 1'b0;
    check("ld_we", 32'(rf_we), 32'd1);
    check("ld_waddr", 32'(rf_waddr), 32'd5);
    check("ld_wbv", wb_wbv, 32'hCAFE0001);
    check("ld_done_busy", 32'(busy), 32'd0);
    check("ld_done_ready", 32'(ex_ready), 32'd1);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    check("held_we", 32'(rf_we), 32'd1);
    check("held_waddr", 32'(rf_waddr), 32'd7);
    check("held_wbv", wb_wbv, 32'h77);
    check("ld_err", 32'(err), 32'd0);
    step();
    check("held_we_end", 32'(rf_we), 32'd0);

    // Suppressed writes: rd=0 and we=0
    drive_ex(1'b1, 5'd0, 1'b1, 1'b0, 32'hAA);
    step();
    check("rd0_we", 32'(rf_we), 32'd0);
    drive_ex(1'b1, 5'd4, 1'b0, 1'b0, 32'hBB);
    step();
    check("we0_we", 32'(rf_we), 32'd0);
    check("we0_wbv_hold", wb_wbv, 32'h77);
    drive_ex(1'b1, 5'd0, 1'b1, 1'b1, 32'h0);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    ld_valid = 1'b1;
    ld_data  = 32'h55;
    step();
    ld_valid = 1'b0;
    check("ld_rd0_we", 32'(rf_we), 32'd0);
    check("ld_rd0_busy", 32'(busy), 32'd0);

`ifdef WB_LD_TIMEOUT_EN
    // Response on the sixteenth wait cycle still writes
    drive_ex(1'b1, 5'd9, 1'b1, 1'b1, 32'h0);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      check("to16_busy", 32'(busy), 32'd1);
      if (i == 15) begin
        ld_valid = 1'b1;
        ld_data  = 32'hB16B00B5;
      end
      step();
    end
    ld_valid = 1'b0;
    check("to16_we", 32'(rf_we), 32'd1);
    check("to16_waddr", 32'(rf_waddr), 32'd9);
    check("to16_wbv", wb_wbv, 32'hB16B00B5);
    check("to16_err", 32'(err), 32'd0);

    // No response: back to IDLE after sixteen wait cycles with err set
    drive_ex(1'b1, 5'd6, 1'b1, 1'b1, 32'h0);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      check("to_busy", 32'(busy), 32'd1);
      check("to_no_we", 32'(rf_we), 32'd0);
      step();
    end
    check("to_idle", 32'(busy), 32'd0);
    check("to_ready", 32'(ex_ready), 32'd1);
    check("to_we", 32'(rf_we), 32'd0);
    check("to_err", 32'(err), 32'd1);
    do_reset();
`else
    // Without the timeout a load waits indefinitely
    drive_ex(1'b1, 5'd6, 1'b1, 1'b1, 32'h0);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      check("long_busy", 32'(busy), 32'd1);
      step();
    end
    check("long_err", 32'(err), 32'd0);
    ld_valid = 1'b1;
    ld_data  = 32'h600D;
    step();
    ld_valid = 1'b0;
    check("long_we", 32'(rf_we), 32'd1);
    check("long_waddr", 32'(rf_waddr), 32'd6);
    check("long_wbv", wb_wbv, 32'h600D);
`endif

    // Spurious ld_valid in IDLE sets sticky err, no write
    ld_valid = 1'b1;
    ld_data  = 32'hFFFF;
    step();
    ld_valid = 1'b0;
    check("spur_we", 32'(rf_we), 32'd0);
    check("spur_err", 32'(err), 32'd1);
    step();
    step();
    check("spur_err_sticky", 32'(err), 32'd1);

    // Spurious response coinciding with a load accept does not complete it
    do_reset();
    check("rst2_err", 32'(err), 32'd0);
    drive_ex(1'b1, 5'd3, 1'b1, 1'b0, 32'h3333);
    step();
    drive_ex(1'b1, 5'd8, 1'b1, 1'b1, 32'h0);
    ld_valid = 1'b1;
    ld_data  = 32'h8888;
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    ld_valid = 1'b0;
    check("coinc_busy", 32'(busy), 32'd1);
    check("coinc_we", 32'(rf_we), 32'd0);
    check("coinc_err", 32'(err), 32'd1);
    check("coinc_waddr", 32'(rf_waddr), 32'd3);

    // Asynchronous reset mid-wait clears everything before any edge
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(ex_ready), 32'd1);
    check("arst_waddr", 32'(rf_waddr), 32'd0);
    check("arst_wbv", wb_wbv, 32'd0);
    check("arst_err", 32'(err), 32'd0);
    step();
    rst = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'h9999;
    step();
    ld_valid = 1'b0;
    check("late_ld_we", 32'(rf_we), 32'd0);
    check("late_ld_err", 32'(err), 32'd1);
    check("late_ld_wbv", wb_wbv, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_writeback.md
# wb_writeback

Writeback-side receiver for the execute→writeback value path. Accepts one result per handshake from execute (ALU value or pending load), waits for the load response where needed, and issues a single registered register-file write per instruction. It is the consuming end of the `ex_wbv`/`wb_wbv` path and the sink that taint-tracking annotations target for writeback data.

## Interface
- `XLEN`, 32, datapath width
- `AW`, 5, register address width (2**AW registers, register 0 hard-wired zero)
- `TIMEOUT`, 16, load-wait limit in cycles (used only with `WB_LD_TIMEOUT_EN`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  execute presents a result
- `ex_ready`  out  1  writeback can accept
- `ex_rd`  in  AW  destination register
- `ex_we`  in  1  instruction writes a register
- `ex_is_ld`  in  1  result comes from memory, `ex_wbv` ignored
- `ex_wbv`  in  XLEN  execute result
- `ld_valid`  in  1  load response strobe, single cycle
- `ld_data`  in  XLEN  load response data
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  AW  write address
- `wb_wbv`  out  XLEN  write data
- `busy`  out  1  a load is outstanding
- `err`  out  1  sticky: spurious `ld_valid` or load timeout

## Operation
- States: IDLE, WAIT_LD. Reset → IDLE.
- `ex_ready` = 1 in IDLE, 0 in WAIT_LD. Combinational from the state only. It never depends on `ex_valid` or `ld_valid`.
- Accept means `ex_valid && ex_ready` at a rising edge.
- Accept with `ex_is_ld=0`:
  - Next cycle: `rf_we = ex_we && (ex_rd != 0)`, `rf_waddr = ex_rd`, `wb_wbv = ex_wbv`.
  - State stays IDLE.
- Accept with `ex_is_ld=1`:
  - Latch `ex_rd` and `ex_we`, then go to WAIT_LD.
  - In WAIT_LD, `ld_valid` sampled high:
    - Next cycle: `rf_we = latched_we && (latched_rd != 0)`, `wb_wbv = ld_data`.
    - State returns to IDLE.
- `rf_we` is a one-cycle pulse per accepted instruction and is 0 otherwise.
- `wb_wbv` and `rf_waddr` hold their last value when `rf_we=0`.
- `busy` = (state == WAIT_LD).
- `ld_valid` in IDLE is spurious:
  - No write occurs.
  - `err` is set.
  - If it arrives in the same cycle as a load accept, it is still spurious. It does not complete the new load.
- `err` clears only on `rst`.

## Timing
- Reset values:
  - `rf_we=0`, `rf_waddr=0`, `wb_wbv=0`, `busy=0`, `err=0`.
  - State IDLE, so `ex_ready=1`.
  - Wait counter 0.
- Non-load latency: accept at edge N → `rf_we` high in cycle N+1.
- Load latency: accept at edge N → `busy` high from N+1. `ld_valid` at edge M (M ≥ N+1) → `rf_we` high in cycle M+1, with `busy`=0 and `ex_ready`=1 in the same cycle.
- Throughput: one non-load per cycle back-to-back. A load blocks acceptance until one cycle after its response.
- Reset mid-WAIT_LD: the pending load is dropped, no write is issued, all outputs take their reset values asynchronously, and a late `ld_valid` after reset counts as spurious.

## Configuration
- `WB_LD_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` increments each WAIT_LD cycle without `ld_valid`.
  - When it reaches `TIMEOUT`, the next edge returns the FSM to IDLE, sets `err`, and issues no write.
  - The counter clears on entry to WAIT_LD.
  - `ld_valid` in the same cycle as the counter reaching `TIMEOUT` wins: the write proceeds normally.
- `WB_LD_TIMEOUT_EN` undefined: no counter, and WAIT_LD persists indefinitely until `ld_valid`.

## Structure
- Shared package `wb_pkg`:
  - state enum `wb_state_t` {IDLE, WAIT_LD}
  - default `XLEN`/`AW` constants
  - struct `wb_req_t` {rd, we, is_ld, wbv}
- Sub-module: `wb_ld_timer` holds the timeout counter. It is instantiated only under `WB_LD_TIMEOUT_EN`.
- All other logic is one flat module.

## Test plan
- Reset, then ALU result `rd=3`, `wbv=0xDEADBEEF` at edge 1 → `rf_we=1`, `rf_waddr=3`, `wb_wbv=0xDEADBEEF` in cycle 2 only.
- Back-to-back ALU results `rd=1`/`0x11`, `rd=2`/`0x22` → two consecutive `rf_we` pulses, with `ex_ready` held at 1.
- Load `rd=5`, `ld_valid` 4 cycles later with `0xCAFE0001`:
  - `busy`=1 and `ex_ready`=0 for 4 cycles.
  - Single write of `rd=5`, `0xCAFE0001`.
  - An `ex_valid` held during the wait is accepted in the write cycle.
- Write to `rd=0`, and a write with `ex_we=0` → `rf_we` stays 0. `ld_valid` in IDLE → no write and `err`=1, holding until reset.
- `WB_LD_TIMEOUT_EN` with `TIMEOUT=16`:
  - Load with no response → IDLE after 16 wait cycles, `err`=1, no write.
  - Response on wait cycle 16 → normal write and `err`=0.
- `rst` asserted asynchronously mid-WAIT_LD → outputs zero immediately, `ex_ready`=1, and a subsequent `ld_valid` sets `err`.
